// File: rtl/sid_vca.sv
// sid_vca: voice amplitude stage. On each CLKen it samples the unsigned
// oscillator waveform and the envelope, recentres the waveform to signed and
// scales it by the envelope with an 8-step serial shift-add multiply. The
// signed product >> 4 is presented on OUT with a one-cycle VALID pulse.
// Optional build macro: SID_VCA_DC_EN adds DC_OFFSET to the result and
// saturates to the signed 16-bit range.
module sid_vca #(
    parameter logic signed [15:0] DC_OFFSET = 16'sh0000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        CLKen,
    input  logic [11:0] WAVE,
    input  logic [7:0]  ENV,
    output logic [15:0] OUT,
    output logic        VALID,
    output logic        BUSY,
    output logic        OVR
);

    typedef enum logic {
        IDLE = 1'b0,
        MUL  = 1'b1
    } state_t;

    state_t             state_reg, state_next;
    logic signed [11:0] w_reg, w_next;
    logic [7:0]         e_reg, e_next;
    logic signed [19:0] acc_reg, acc_next;
    logic [2:0]         count_reg, count_next;
    logic [15:0]        out_reg, out_next;
    logic               valid_reg, valid_next;
    logic               busy_reg, busy_next;
    logic               ovr_reg, ovr_next;

    // Sign-extended waveform and its eight possible shifted copies; the
    // step counter selects which one is added on each MUL cycle.
    logic signed [19:0] w_ext;
    logic signed [19:0] shifted_w [8];
    logic signed [19:0] addend;
    logic signed [19:0] acc_sum;
    logic [15:0]        result;

    assign w_ext = {{8{w_reg[11]}}, w_reg};

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_shift
            assign shifted_w[gi] = w_ext <<< gi;
        end
    endgenerate

    assign addend  = e_reg[count_reg] ? shifted_w[count_reg] : 20'sd0;
    assign acc_sum = acc_reg + addend;

`ifdef SID_VCA_DC_EN
    // Bias the truncated product and clamp, summing at 17 bits so the
    // overflow is visible in the top two bits.
    logic signed [16:0] dc_sum;
    assign dc_sum = {acc_sum[19], acc_sum[19:4]} + {DC_OFFSET[15], DC_OFFSET};
    assign result = (dc_sum[16] != dc_sum[15])
                  ? (dc_sum[16] ? 16'h8000 : 16'h7FFF)
                  : dc_sum[15:0];
`else
    // |W*E| >> 4 always fits in 16 bits, so plain truncation suffices.
    assign result = acc_sum[19:4];
    // DC_OFFSET has no effect in this build; this empty block only
    // references it so the parameter is not flagged as dangling.
    generate
        if (DC_OFFSET != 16'sh0000) begin : g_dc_offset_ignored
        end
    endgenerate
`endif

    // Next-state and datapath control: start a multiply from IDLE, step the
    // shift-add in MUL, publish the result on the eighth step.
    always_comb begin
        state_next = state_reg;
        w_next     = w_reg;
        e_next     = e_reg;
        acc_next   = acc_reg;
        count_next = count_reg;
        out_next   = out_reg;
        valid_next = 1'b0;
        busy_next  = busy_reg;
        ovr_next   = ovr_reg;
        case (state_reg)
            IDLE: begin
                if (CLKen) begin
                    w_next     = $signed(WAVE - 12'h800);
                    e_next     = ENV;
                    acc_next   = 20'sd0;
                    count_next = 3'd0;
                    busy_next  = 1'b1;
                    state_next = MUL;
                end
            end
            MUL: begin
                // A strobe arriving mid-multiply is dropped but remembered.
                if (CLKen) begin
                    ovr_next = 1'b1;
                end
                acc_next   = acc_sum;
                count_next = count_reg + 3'd1;
                if (count_reg == 3'd7) begin
                    out_next   = result;
                    valid_next = 1'b1;
                    busy_next  = 1'b0;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
                busy_next  = 1'b0;
            end
        endcase
    end

    // State and datapath registers with asynchronous clear.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_reg <= IDLE;
            w_reg     <= 12'sd0;
            e_reg     <= 8'd0;
            acc_reg   <= 20'sd0;
            count_reg <= 3'd0;
            out_reg   <= 16'd0;
            valid_reg <= 1'b0;
            busy_reg  <= 1'b0;
            ovr_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            w_reg     <= w_next;
            e_reg     <= e_next;
            acc_reg   <= acc_next;
            count_reg <= count_next;
            out_reg   <= out_next;
            valid_reg <= valid_next;
            busy_reg  <= busy_next;
            ovr_reg   <= ovr_next;
        end
    end

    assign OUT   = out_reg;
    assign VALID = valid_reg;
    assign BUSY  = busy_reg;
    assign OVR   = ovr_reg;

endmodule

// File: tb/tb_sid_vca.sv
// tb_sid_vca: self-checking bench for sid_vca. Directed table vectors,
// hand-written overrun and mid-multiply reset sequences, and randomized
// transactions checked against an arithmetic reference model.
module tb_sid_vca;

`ifdef SID_VCA_DC_EN
    localparam int DC = 256;
`else
    localparam int DC = 0;
`endif

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        CLKen = 1'b0;
    logic [11:0] WAVE = 12'd0;
    logic [7:0]  ENV = 8'd0;
    logic [15:0] OUT;
    logic        VALID;
    logic        BUSY;
    logic        OVR;

    int errors = 0;
    int checks = 0;

    sid_vca #(
        .DC_OFFSET(16'(DC))
    ) dut (
        .CLK  (CLK),
        .RST  (RST),
        .CLKen(CLKen),
        .WAVE (WAVE),
        .ENV  (ENV),
        .OUT  (OUT),
        .VALID(VALID),
        .BUSY (BUSY),
        .OVR  (OVR)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [11:0] wave;
        logic [7:0]  env;
        logic [15:0] exp_out;
    } vec_t;

    // Reference: signed product, floor-divided by 16, optional bias + clamp.
    function automatic logic [15:0] model(input logic [11:0] w, input logic [7:0] e);
        int p;
        int r;
        p = (int'(w) - 2048) * int'(e);
        r = (p >>> 4) + DC;
        if (r > 32767) r = 32767;
        if (r < -32768) r = -32768;
        return r[15:0];
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Edges t1..t8 of a multiply already started; operands are scrambled
    // each cycle to show they were latched at t0.
    task automatic finish_mul(input logic [15:0] exp, input string name);
        for (int i = 1; i <= 7; i++) begin
            WAVE = 12'($urandom);
            ENV  = 8'($urandom);
            tick();
            check({name, " busy_mid"}, 16'(BUSY), 16'd1);
            check({name, " valid_mid"}, 16'(VALID), 16'd0);
        end
        tick();
        check({name, " valid"}, 16'(VALID), 16'd1);
        check({name, " busy_end"}, 16'(BUSY), 16'd0);
        check({name, " out"}, OUT, exp);
        $display("txn %s: OUT=%h expected=%h", name, OUT, exp);
    endtask

    task automatic start_mul(input logic [11:0] w, input logic [7:0] e, input string name);
        WAVE  = w;
        ENV   = e;
        CLKen = 1'b1;
        tick();
        CLKen = 1'b0;
        check({name, " busy_t0"}, 16'(BUSY), 16'd1);
        check({name, " valid_t0"}, 16'(VALID), 16'd0);
    endtask

    vec_t vecs [5];

    initial begin
`ifdef SID_VCA_DC_EN
        vecs[0] = '{12'hFFF, 8'hFF, 16'h7FFF};
        vecs[1] = '{12'h000, 8'hFF, 16'h8180};
        vecs[2] = '{12'h900, 8'h80, 16'h0900};
        vecs[3] = '{12'hABC, 8'h00, 16'h0100};
        vecs[4] = '{12'h800, 8'hFF, 16'h0100};
`else
        vecs[0] = '{12'hFFF, 8'hFF, 16'h7F70};
        vecs[1] = '{12'h000, 8'hFF, 16'h8080};
        vecs[2] = '{12'h900, 8'h80, 16'h0800};
        vecs[3] = '{12'hABC, 8'h00, 16'h0000};
        vecs[4] = '{12'h800, 8'hFF, 16'h0000};
`endif

        // Reset state.
        tick();
        tick();
        check("rst out", OUT, 16'd0);
        check("rst flags", {13'd0, VALID, BUSY, OVR}, 16'd0);
        RST = 1'b0;
        tick();

        // Directed vectors, back to back.
        foreach (vecs[i]) begin
            start_mul(vecs[i].wave, vecs[i].env, $sformatf("vec%0d", i));
            finish_mul(vecs[i].exp_out, $sformatf("vec%0d", i));
        end
        tick();
        check("valid one cycle", 16'(VALID), 16'd0);
        check("out held", OUT, vecs[4].exp_out);
        check("no ovr yet", 16'(OVR), 16'd0);

        // Overrun: second strobe at t4 dropped, OVR sticks, t9 accepted.
        start_mul(12'hFFF, 8'hFF, "ovr");
        tick();
        tick();
        tick();
        WAVE  = 12'h000;
        ENV   = 8'h01;
        CLKen = 1'b1;
        tick();
        CLKen = 1'b0;
        check("ovr set", 16'(OVR), 16'd1);
        check("ovr busy", 16'(BUSY), 16'd1);
        for (int i = 5; i <= 7; i++) tick();
        check("ovr no early valid", 16'(VALID), 16'd0);
        tick();
        check("ovr valid", 16'(VALID), 16'd1);
        check("ovr out", OUT, vecs[0].exp_out);
        $display("txn ovr: OUT=%h OVR=%0d", OUT, OVR);
        start_mul(12'h900, 8'h80, "t9");
        finish_mul(vecs[2].exp_out, "t9");
        check("ovr sticky", 16'(OVR), 16'd1);

        // Reset mid-multiply at t3.
        start_mul(12'hFFF, 8'hFF, "rstmid");
        tick();
        tick();
        tick();
        RST = 1'b1;
        #1;
        check("rstmid out", OUT, 16'd0);
        check("rstmid flags", {13'd0, VALID, BUSY, OVR}, 16'd0);
        tick();
        RST = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("rstmid no valid", {14'd0, VALID, BUSY}, 16'd0);
        end
        $display("txn rstmid: OUT=%h", OUT);
        start_mul(12'h000, 8'hFF, "post_rst");
        finish_mul(vecs[1].exp_out, "post_rst");

        // Randomized transactions against the reference model.
        for (int n = 0; n < 40; n++) begin
            logic [11:0] w;
            logic [7:0]  e;
            int gap;
            w = 12'($urandom);
            e = 8'($urandom);
            if (n % 8 == 0) w = (n % 16 == 0) ? 12'h000 : 12'hFFF;
            if (n % 5 == 0) e = 8'hFF;
            gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) tick();
            start_mul(w, e, $sformatf("rnd%0d", n));
            finish_mul(model(w, e), $sformatf("rnd%0d", n));
        end
        check("rnd no ovr", 16'(OVR), 16'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sid_vca.md
Name: sid_vca

Overview:
- Voice amplitude stage, directly downstream of the voice envelope generator.
- Each 1 MHz tick it samples the 12-bit unsigned oscillator waveform and the 8-bit envelope value.
- It centres the waveform to signed, then scales it by the envelope using a serial shift-add multiplier.
- The result is a signed 16-bit voice sample for the voice mixer/filter.
- One multiply per CLKen; no multiplier primitive is used.

Parameters:
- DC_OFFSET, 16'sh0000: signed constant added to the result. Used only when SID_VCA_DC_EN is defined.

Ports:
- CLK  input  1  master clock
- RST  input  1  asynchronous reset, active-high
- CLKen  input  1  1 MHz sample strobe, one CLK wide
- WAVE  input  12  unsigned waveform from oscillator
- ENV  input  8  envelope value from the envelope generator output
- OUT  output  16  signed scaled voice sample, held between updates
- VALID  output  1  one-cycle pulse: OUT has just been updated
- BUSY  output  1  high while a multiply is in progress
- OVR  output  1  sticky: a CLKen arrived while BUSY

Behaviour:
- Reset (async, RST high):
  - state=IDLE; OUT=0, VALID=0, BUSY=0, OVR=0.
  - Accumulator, counter and operand registers cleared.
  - Any partial product is discarded.
- States: IDLE, MUL.
- Edge t0, IDLE with CLKen=1:
  - Latch W = WAVE - 12'h800 as signed 12-bit (range -2048..2047).
  - Latch E = ENV.
  - Clear the 20-bit signed accumulator ACC; count=0.
  - state->MUL; BUSY=1.
- Edges t1..t8 in MUL:
  - If E[count]==1: ACC <= ACC + (sign-extended W << count), 20-bit signed arithmetic.
  - count increments.
- At edge t8 (count==7):
  - OUT <= final ACC[19:4] (arithmetic truncation, no rounding).
  - VALID <= 1 for exactly one cycle.
  - state->IDLE; BUSY <= 0.
- Latency: OUT/VALID are visible 8 CLK edges after the sampling edge. Minimum CLKen spacing is 9 CLK.
- Range: P = W*E lies in -522240..521985; P>>4 lies in -32640..32624. This fits 16-bit, so no saturation is needed in the base build.
- CLKen while state==MUL (including at t8):
  - The sample is dropped; the in-flight multiply is unaffected.
  - OVR <= 1 and stays 1 until RST.
- CLKen in IDLE on the cycle after VALID is accepted normally.
- ENV/WAVE changes during MUL have no effect; operands are latched at t0.
- E==0 or W==0: full 8-cycle sequence still runs; OUT=0, VALID still pulses.
- OUT changes only on the VALID edge or on reset.

Optional Feature:
- Macro: SID_VCA_DC_EN.
- Defined:
  - At t8, compute OUT <= sat16(ACC[19:4] + DC_OFFSET), where sat16 clamps to 16'h7FFF..16'h8000.
  - The sum is computed at 17 bits before clamping.
  - Models the 6581 DC bias.
- Undefined:
  - No adder or saturation logic is built; DC_OFFSET is ignored.
  - OUT = ACC[19:4] exactly.
- Timing, VALID, BUSY and OVR are identical in both builds.

Test Plan:
- WAVE=12'hFFF, ENV=8'hFF, CLKen at t0 -> BUSY for 8 cycles, VALID pulse after edge t8, OUT=16'h7F70 (32624).
- WAVE=12'h000, ENV=8'hFF -> OUT=16'h8080 (-32640). WAVE=12'h900, ENV=8'h80 -> OUT=16'h0800.
- ENV=8'h00 with WAVE=12'hABC, then WAVE=12'h800 with ENV=8'hFF -> OUT=0 both times, VALID pulses both times.
- CLKen at t0 (WAVE=12'hFFF, ENV=8'hFF), second CLKen at t4 -> second dropped, OVR=1 sticky, OUT=16'h7F70; CLKen at t9 accepted.
- RST pulse at t3 of a multiply -> OUT=0, VALID/BUSY/OVR=0 immediately, no VALID afterward; next CLKen works normally.
- SID_VCA_DC_EN, DC_OFFSET=16'sh0100:
  - WAVE=12'hFFF, ENV=8'hFF -> OUT=16'h7FFF (saturated).
  - WAVE=12'h800, ENV=8'hFF -> OUT=16'h0100.
